alu_op_sequencer: RTL and testbench

//  Initiator side of the 6502 ALU: takes one operation request on a valid/ready handshake.

---
 rtl/alu_seq_pkg.sv | 49 ++++
 rtl/alu_seq_flag_reg.sv | 35 +++
 rtl/alu_op_sequencer.sv | 181 ++++++++++++++++++
 tb/tb_alu_op_sequencer.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/alu_seq_pkg.sv
// Shared types for the 6502 ALU operation sequencer: op codes, FSM states,
// NVZC flag bit positions and the registered ALU control bundle.
package alu_seq_pkg;

   typedef enum logic [3:0] {
      ADC = 4'd0,
      SBC = 4'd1,
      AND = 4'd2,
      ORA = 4'd3,
      EOR = 4'd4,
      LSR = 4'd5,
      ROR = 4'd6,
      ASL = 4'd7,
      ROL = 4'd8
   } op_e;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      ADJ  = 2'd2,
      RESP = 2'd3
   } state_e;

   localparam int FLAG_N = 3;
   localparam int FLAG_V = 2;
   localparam int FLAG_Z = 1;
   localparam int FLAG_C = 0;

   typedef struct packed {
      logic [7:0] a;
      logic [7:0] b;
      logic       i_addc;
      logic       daa;
      logic       sums;
      logic       ands;
      logic       ors;
      logic       eors;
      logic       srs;
   } alu_ctrl_t;

   function automatic logic op_legal(input logic [3:0] op);
      return op <= 4'd8;
   endfunction

   function automatic logic op_is_logic(input logic [3:0] op);
      return (op == AND) || (op == ORA) || (op == EOR);
   endfunction

endpackage

// File: rtl/alu_seq_flag_reg.sv
// NVZC flag register: op result updates take priority, direct loads are
// only honoured while the sequencer is idle. N and Z derive from the result.
module alu_seq_flag_reg
   import alu_seq_pkg::*;
#(
   parameter logic [3:0] FLAGS_RESET = 4'b0000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       wr_allow,
   input  logic       flag_wr,
   input  logic [3:0] flag_wr_data,
   input  logic       upd_en,
   input  logic [7:0] upd_res,
   input  logic       upd_c_en,
   input  logic       upd_c,
   input  logic       upd_v_en,
   input  logic       upd_v,
   output logic [3:0] flags
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         flags <= FLAGS_RESET;
      end else if (upd_en) begin
         flags[FLAG_N] <= upd_res[7];
         flags[FLAG_Z] <= (upd_res == 8'h00);
         if (upd_c_en) flags[FLAG_C] <= upd_c;
         if (upd_v_en) flags[FLAG_V] <= upd_v;
      end else if (flag_wr && wr_allow) begin
         flags <= flag_wr_data;
      end
   end

endmodule

// File: rtl/alu_op_sequencer.sv
// Initiator for the 6502 ALU: accepts one op, drives the ALU, optionally runs
// the decimal adjuster, returns result and NVZC. Option: ALU_SEQ_PIPELINE_EN.
//
// state | meaning
// IDLE  | waiting for a request, direct flag loads allowed
// EXEC  | ALU controls driven, ALU result captured at the end
// ADJ   | decimal ADC/SBC: captured sum routed through the adjuster
// RESP  | result beat valid until res_ready
module alu_op_sequencer
   import alu_seq_pkg::*;
#(
   parameter logic [3:0] FLAGS_RESET     = 4'b0000,
   parameter bit         DECIMAL_SUPPORT = 1'b1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       op_valid,
   output logic       op_ready,
   input  logic [3:0] op_code,
   input  logic [7:0] op_a,
   input  logic [7:0] op_b,
   input  logic       decimal_mode,
   input  logic       flag_wr,
   input  logic [3:0] flag_wr_data,
   output logic       res_valid,
   input  logic       res_ready,
   output logic [7:0] res_data,
   output logic [3:0] res_flags,
   output logic [7:0] alu_a,
   output logic [7:0] alu_b,
   output logic       alu_i_addc,
   output logic       alu_daa,
   output logic       alu_sums,
   output logic       alu_ands,
   output logic       alu_ors,
   output logic       alu_eors,
   output logic       alu_srs,
   input  logic [7:0] alu_out,
   input  logic       alu_acr,
   input  logic       alu_hc,
   input  logic       alu_avr,
   output logic       dadj_daa,
   output logic       dadj_dsa,
   output logic       dadj_hc,
   output logic       dadj_acr,
   output logic [7:0] dadj_sb,
   input  logic [7:0] dadj_sb_ac
);

   state_e     state;
   alu_ctrl_t  ctrl_q, ctrl_nx;
   logic [3:0] op_q;
   logic [7:0] a_q;
   logic       dec_q, avr_q;
   logic [3:0] flags;
   logic       accept, cin, dec_en, needs_adj;
   logic       upd_en, upd_c, upd_v;
   logic [7:0] upd_res;

`ifdef ALU_SEQ_PIPELINE_EN
   assign op_ready = (state == IDLE) || ((state == RESP) && res_ready);
`else
   assign op_ready = (state == IDLE);
`endif

   assign accept    = op_valid && op_ready;
   assign dec_en    = DECIMAL_SUPPORT && decimal_mode;
   assign needs_adj = dec_q && ((op_q == ADC) || (op_q == SBC));
   // A load coinciding with accept supplies the carry-in for that op.
   assign cin       = (flag_wr && (state == IDLE)) ? flag_wr_data[FLAG_C] : flags[FLAG_C];

   always_comb begin
      ctrl_nx   = '0;
      ctrl_nx.a = op_a;
      case (op_code)
         ADC: begin ctrl_nx.b = op_b;  ctrl_nx.sums = 1'b1; ctrl_nx.i_addc = cin; ctrl_nx.daa = dec_en; end
         SBC: begin ctrl_nx.b = ~op_b; ctrl_nx.sums = 1'b1; ctrl_nx.i_addc = cin; end
         AND: begin ctrl_nx.b = op_b;  ctrl_nx.ands = 1'b1; end
         ORA: begin ctrl_nx.b = op_b;  ctrl_nx.ors  = 1'b1; end
         EOR: begin ctrl_nx.b = op_b;  ctrl_nx.eors = 1'b1; end
         LSR: ctrl_nx.srs = 1'b1;
         ROR: begin ctrl_nx.srs = 1'b1; ctrl_nx.i_addc = cin; end
         ASL: begin ctrl_nx.b = op_a;  ctrl_nx.sums = 1'b1; end
         ROL: begin ctrl_nx.b = op_a;  ctrl_nx.sums = 1'b1; ctrl_nx.i_addc = cin; end
         default: ctrl_nx.a = 8'h00;
      endcase
   end

   assign alu_a      = ctrl_q.a;
   assign alu_b      = ctrl_q.b;
   assign alu_i_addc = ctrl_q.i_addc;
   assign alu_daa    = ctrl_q.daa;
   assign alu_sums   = ctrl_q.sums;
   assign alu_ands   = ctrl_q.ands;
   assign alu_ors    = ctrl_q.ors;
   assign alu_eors   = ctrl_q.eors;
   assign alu_srs    = ctrl_q.srs;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         ctrl_q    <= '0;
         op_q      <= '0;
         a_q       <= '0;
         dec_q     <= 1'b0;
         avr_q     <= 1'b0;
         res_valid <= 1'b0;
         res_data  <= '0;
         dadj_daa  <= 1'b0;
         dadj_dsa  <= 1'b0;
         dadj_hc   <= 1'b0;
         dadj_acr  <= 1'b0;
         dadj_sb   <= '0;
      end else begin
         case (state)
            IDLE: if (accept) state <= EXEC;
            EXEC: begin
               ctrl_q <= '0;
               if (needs_adj) begin
                  state    <= ADJ;
                  dadj_sb  <= alu_out;
                  dadj_hc  <= alu_hc;
                  dadj_acr <= alu_acr;
                  dadj_daa <= (op_q == ADC);
                  dadj_dsa <= (op_q == SBC);
                  avr_q    <= alu_avr;
               end else begin
                  state     <= RESP;
                  res_valid <= 1'b1;
                  res_data  <= op_legal(op_q) ? alu_out : a_q;
               end
            end
            ADJ: begin
               state     <= RESP;
               res_valid <= 1'b1;
               res_data  <= dadj_sb_ac;
               dadj_daa  <= 1'b0;
               dadj_dsa  <= 1'b0;
               dadj_hc   <= 1'b0;
               dadj_acr  <= 1'b0;
               dadj_sb   <= '0;
            end
            RESP: if (res_ready) begin
               res_valid <= 1'b0;
               state     <= accept ? EXEC : IDLE;
            end
            default: state <= IDLE;
         endcase
         if (accept) begin
            ctrl_q <= ctrl_nx;
            op_q   <= op_code;
            a_q    <= op_a;
            dec_q  <= dec_en;
         end
      end
   end

   // Flags commit on the same edge the result is registered.
   assign upd_en  = ((state == EXEC) && !needs_adj && op_legal(op_q)) || (state == ADJ);
   assign upd_res = (state == ADJ) ? dadj_sb_ac : alu_out;
   assign upd_c   = (state == ADJ) ? dadj_acr : alu_acr;
   assign upd_v   = (state == ADJ) ? avr_q : alu_avr;

   alu_seq_flag_reg #(.FLAGS_RESET(FLAGS_RESET)) u_flag_reg (
      .clk          (clk),
      .rst_n        (rst_n),
      .wr_allow     (state == IDLE),
      .flag_wr      (flag_wr),
      .flag_wr_data (flag_wr_data),
      .upd_en       (upd_en),
      .upd_res      (upd_res),
      .upd_c_en     (!op_is_logic(op_q)),
      .upd_c        (upd_c),
      .upd_v_en     ((op_q == ADC) || (op_q == SBC)),
      .upd_v        (upd_v),
      .flags        (flags)
   );

   assign res_flags = flags;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer with behavioural 6502 ALU and decimal adjuster.
module tb_alu_op_sequencer;
   import alu_seq_pkg::*;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       op_valid, op_ready, decimal_mode, flag_wr;
   logic [3:0] op_code, flag_wr_data, res_flags;
   logic [7:0] op_a, op_b, res_data;
   logic       res_valid, res_ready;
   logic [7:0] alu_a, alu_b, alu_out, dadj_sb, dadj_sb_ac;
   logic       alu_i_addc, alu_daa, alu_sums, alu_ands, alu_ors, alu_eors, alu_srs;
   logic       alu_acr, alu_hc, alu_avr;
   logic       dadj_daa, dadj_dsa, dadj_hc, dadj_acr;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   alu_op_sequencer dut (
      .clk(clk), .rst_n(rst_n), .op_valid(op_valid), .op_ready(op_ready),
      .op_code(op_code), .op_a(op_a), .op_b(op_b), .decimal_mode(decimal_mode),
      .flag_wr(flag_wr), .flag_wr_data(flag_wr_data), .res_valid(res_valid),
      .res_ready(res_ready), .res_data(res_data), .res_flags(res_flags),
      .alu_a(alu_a), .alu_b(alu_b), .alu_i_addc(alu_i_addc), .alu_daa(alu_daa),
      .alu_sums(alu_sums), .alu_ands(alu_ands), .alu_ors(alu_ors), .alu_eors(alu_eors),
      .alu_srs(alu_srs), .alu_out(alu_out), .alu_acr(alu_acr), .alu_hc(alu_hc),
      .alu_avr(alu_avr), .dadj_daa(dadj_daa), .dadj_dsa(dadj_dsa), .dadj_hc(dadj_hc),
      .dadj_acr(dadj_acr), .dadj_sb(dadj_sb), .dadj_sb_ac(dadj_sb_ac)
   );

   // 6502 ALU: nibble adders with decimal carry generation when daa is set.
   logic [4:0] lo, hi;
   logic [8:0] bsum;
   logic       hc_m, acr_m;
   always_comb begin
      lo      = {1'b0, alu_a[3:0]} + {1'b0, alu_b[3:0]} + {4'b0, alu_i_addc};
      hc_m    = alu_daa ? (lo > 5'd9) : lo[4];
      hi      = {1'b0, alu_a[7:4]} + {1'b0, alu_b[7:4]} + {4'b0, hc_m};
      acr_m   = alu_daa ? (hi > 5'd9) : hi[4];
      bsum    = {1'b0, alu_a} + {1'b0, alu_b} + {8'b0, alu_i_addc};
      alu_out = 8'h00;
      alu_acr = 1'b0;
      alu_hc  = 1'b0;
      alu_avr = 1'b0;
      if (alu_sums) begin
         alu_out = {hi[3:0], lo[3:0]};
         alu_acr = acr_m;
         alu_hc  = hc_m;
         alu_avr = (alu_a[7] == alu_b[7]) && (bsum[7] != alu_a[7]);
      end else if (alu_ands) alu_out = alu_a & alu_b;
      else if (alu_ors)  alu_out = alu_a | alu_b;
      else if (alu_eors) alu_out = alu_a ^ alu_b;
      else if (alu_srs) begin
         alu_out = {alu_i_addc, alu_a[7:1]};
         alu_acr = alu_a[0];
      end
   end

   always_comb begin
      dadj_sb_ac = dadj_sb;
      if (dadj_daa) begin
         if (dadj_hc)  dadj_sb_ac[3:0] = dadj_sb_ac[3:0] + 4'd6;
         if (dadj_acr) dadj_sb_ac[7:4] = dadj_sb_ac[7:4] + 4'd6;
      end
      if (dadj_dsa) begin
         if (!dadj_hc)  dadj_sb_ac[3:0] = dadj_sb_ac[3:0] - 4'd6;
         if (!dadj_acr) dadj_sb_ac[7:4] = dadj_sb_ac[7:4] - 4'd6;
      end
   end

   typedef struct {
      logic [7:0] res;
      logic [3:0] flags;
      int         lat;
   } exp_t;
   exp_t exp_q[$];

   typedef struct {
      logic [3:0] op;
      logic [7:0] a;
      logic [7:0] b;
      logic       dec;
      logic [3:0] ldv;
      logic [7:0] res;
      logic [3:0] flags;
      int         lat;
   } vec_t;
   vec_t vt[15];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // mode 0: no flag load, 1: load before op, 2: load on accept edge, 3: load attempt during EXEC
   task automatic issue(input string nm, input logic [3:0] op, input logic [7:0] a, b,
                        input logic dec, input int mode, input logic [3:0] ldv,
                        input logic [7:0] er, input logic [3:0] ef, input int el);
      exp_t e;
      int   lat;
      if (mode == 1) begin
         flag_wr = 1'b1; flag_wr_data = ldv;
         @(posedge clk); #1;
         flag_wr = 1'b0;
      end
      op_valid = 1'b1; op_code = op; op_a = a; op_b = b; decimal_mode = dec;
      if (mode == 2) begin flag_wr = 1'b1; flag_wr_data = ldv; end
      chk({nm, " op_ready"}, 32'(op_ready), 32'd1);
      e.res = er; e.flags = ef; e.lat = el;
      exp_q.push_back(e);
      @(posedge clk); #1;
      op_valid = 1'b0; decimal_mode = 1'b0; flag_wr = 1'b0;
      if (mode == 3) begin flag_wr = 1'b1; flag_wr_data = ldv; end
      lat = 1;
      while (!res_valid && lat < 10) begin
         @(posedge clk); #1;
         flag_wr = 1'b0;
         lat++;
      end
      flag_wr = 1'b0;
      e = exp_q.pop_front();
      chk({nm, " latency"}, 32'(lat), 32'(e.lat));
      chk({nm, " res_data"}, 32'(res_data), 32'(e.res));
      chk({nm, " res_flags"}, 32'(res_flags), 32'(e.flags));
      res_ready = 1'b1;
      @(posedge clk); #1;
      res_ready = 1'b0;
      chk({nm, " res_valid drop"}, 32'(res_valid), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vt[0]  = '{ADC, 8'h50, 8'h50, 1'b0, 4'b0000, 8'hA0, 4'b1100, 2};
      vt[1]  = '{SBC, 8'h00, 8'h01, 1'b0, 4'b0001, 8'hFF, 4'b1000, 2};
      vt[2]  = '{ADC, 8'h09, 8'h01, 1'b1, 4'b0000, 8'h10, 4'b0000, 3};
      vt[3]  = '{ADC, 8'h99, 8'h01, 1'b1, 4'b0000, 8'h00, 4'b0011, 3};
      vt[4]  = '{SBC, 8'h10, 8'h01, 1'b1, 4'b0001, 8'h09, 4'b0001, 3};
      vt[5]  = '{LSR, 8'h03, 8'h00, 1'b0, 4'b0001, 8'h01, 4'b0001, 2};
      vt[6]  = '{ROR, 8'h02, 8'h00, 1'b0, 4'b0001, 8'h81, 4'b1000, 2};
      vt[7]  = '{AND, 8'hF0, 8'h3C, 1'b0, 4'b0001, 8'h30, 4'b0001, 2};
      vt[8]  = '{ORA, 8'h00, 8'h00, 1'b0, 4'b0000, 8'h00, 4'b0010, 2};
      vt[9]  = '{EOR, 8'hFF, 8'h0F, 1'b0, 4'b0100, 8'hF0, 4'b1100, 2};
      vt[10] = '{ASL, 8'h81, 8'h00, 1'b0, 4'b0000, 8'h02, 4'b0001, 2};
      vt[11] = '{ROL, 8'h80, 8'h00, 1'b0, 4'b0001, 8'h01, 4'b0001, 2};
      vt[12] = '{4'd9, 8'h5A, 8'h33, 1'b0, 4'b1001, 8'h5A, 4'b1001, 2};
      vt[13] = '{ADC, 8'hFF, 8'h01, 1'b0, 4'b0000, 8'h00, 4'b0011, 2};
      vt[14] = '{AND, 8'hFF, 8'h80, 1'b1, 4'b0000, 8'h80, 4'b1000, 2};

      rst_n = 1'b0; op_valid = 1'b0; op_code = 4'd0; op_a = 8'h00; op_b = 8'h00;
      decimal_mode = 1'b0; flag_wr = 1'b0; flag_wr_data = 4'd0; res_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("reset op_ready", 32'(op_ready), 32'd1);
      chk("reset res_valid", 32'(res_valid), 32'd0);
      chk("reset res_data", 32'(res_data), 32'd0);
      chk("reset res_flags", 32'(res_flags), 32'd0);
      chk("reset alu outputs", 32'({alu_a, alu_b, alu_i_addc, alu_daa, alu_sums, alu_ands,
          alu_ors, alu_eors, alu_srs}), 32'd0);
      chk("reset dadj outputs", 32'({dadj_sb, dadj_daa, dadj_dsa, dadj_hc, dadj_acr}), 32'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      for (int i = 0; i < 15; i++)
         issue($sformatf("vec%0d", i), vt[i].op, vt[i].a, vt[i].b, vt[i].dec, 1,
               vt[i].ldv, vt[i].res, vt[i].flags, vt[i].lat);

      // Shift chain: ROR picks up the C left by LSR.
      issue("seq lsr", LSR, 8'h03, 8'h00, 1'b0, 1, 4'b0001, 8'h01, 4'b0001, 2);
      issue("seq ror", ROR, 8'h02, 8'h00, 1'b0, 0, 4'b0000, 8'h81, 4'b1000, 2);

      // Carry-in from a flag load on the accept edge, then a load during EXEC is ignored.
      issue("fw clear", ORA, 8'h01, 8'h00, 1'b0, 1, 4'b0000, 8'h01, 4'b0000, 2);
      issue("fw accept", ADC, 8'h01, 8'h01, 1'b0, 2, 4'b0001, 8'h03, 4'b0000, 2);
      issue("fw exec", ADC, 8'h01, 8'h01, 1'b0, 3, 4'b1111, 8'h02, 4'b0000, 2);

      // Backpressure: result holds while a competing request is presented.
      op_valid = 1'b1; op_code = ADC; op_a = 8'h50; op_b = 8'h50;
      @(posedge clk); #1;
      op_code = SBC; op_a = 8'h11; op_b = 8'h22;
      @(posedge clk); #1;
      chk("bp first valid", 32'(res_valid), 32'd1);
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         chk($sformatf("bp%0d res_valid", i), 32'(res_valid), 32'd1);
         chk($sformatf("bp%0d res_data", i), 32'(res_data), 32'hA0);
         chk($sformatf("bp%0d res_flags", i), 32'(res_flags), 32'hC);
         chk($sformatf("bp%0d op_ready", i), 32'(op_ready), 32'd0);
      end
      op_valid = 1'b0;
      res_ready = 1'b1;
      @(posedge clk); #1;
      res_ready = 1'b0;
      chk("bp consumed", 32'(res_valid), 32'd0);
      chk("bp idle ready", 32'(op_ready), 32'd1);

      // Reset while the decimal adjuster is active.
      flag_wr = 1'b1; flag_wr_data = 4'b1110;
      @(posedge clk); #1;
      flag_wr = 1'b0;
      chk("rst pre flags", 32'(res_flags), 32'hE);
      op_valid = 1'b1; op_code = ADC; op_a = 8'h09; op_b = 8'h01; decimal_mode = 1'b1;
      @(posedge clk); #1;
      op_valid = 1'b0; decimal_mode = 1'b0;
      chk("rst exec daa", 32'(alu_daa), 32'd1);
      @(posedge clk); #1;
      chk("rst adj daa", 32'(dadj_daa), 32'd1);
      chk("rst adj sb", 32'(dadj_sb), 32'h1A);
      chk("rst adj hc", 32'(dadj_hc), 32'd1);
      rst_n = 1'b0;
      #2;
      chk("rst flags", 32'(res_flags), 32'd0);
      chk("rst res_valid", 32'(res_valid), 32'd0);
      chk("rst op_ready", 32'(op_ready), 32'd1);
      chk("rst dadj cleared", 32'(dadj_daa), 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      res_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         chk($sformatf("rst no beat%0d", i), 32'(res_valid), 32'd0);
      end
      res_ready = 1'b0;
      issue("post rst", ADC, 8'h01, 8'h02, 1'b0, 0, 4'b0000, 8'h03, 4'b0000, 2);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
